// File: rtl/chunked_adder_sequencer.sv
// Adds two WIDTH-bit operands one CHUNK slice per cycle through a shared adder; result valid NCHUNK cycles after accept.
// Backpressure: result held in DONE until res_ready; start_ready only in IDLE, no queueing or same-edge turnaround.
module chunked_adder_sequencer #(
    parameter int WIDTH = 12,
    parameter int CHUNK = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [CHUNK:0]   slice;

    // One CHUNK-bit ripple slice; carry between slices only flows through the carry register.
    always_comb begin
        slice = {1'b0, a_r[idx*CHUNK +: CHUNK]}
              + {1'b0, b_r[idx*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry};
    end

    assign start_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_r   <= a_in;
                        b_r   <= b_in;
                        carry <= cin;
                        sum   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[idx*CHUNK +: CHUNK] <= slice[CHUNK-1:0];
                    carry <= slice[CHUNK];
                    if (idx == LAST) begin
                        cout      <= slice[CHUNK];
                        idx       <= '0;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    idx       <= '0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/chunked_adder_sequencer.md
Name: chunked_adder_sequencer

Overview:
- Multi-cycle controller that adds two WIDTH-bit operands by pushing CHUNK-bit slices, LSB slice first, through one shared CHUNK-bit ripple-carry adder slice.
- Holds a carry register between slices.
- Accepts operands and returns the result over valid/ready handshakes.
- Lets narrow adder hardware serve wider operands in the digital-systems datapath.

Parameters:
- WIDTH, 12, operand and sum width in bits; must be an integer multiple of CHUNK.
- CHUNK, 3, bits added per cycle (width of the shared adder slice).
- NCHUNK, WIDTH/CHUNK, derived (localparam): number of RUN cycles per operation.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- start_valid  input  1  requester has operands on a_in/b_in/cin.
- start_ready  output  1  block can accept a new operation.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- cin  input  1  carry-in to the least-significant slice.
- res_valid  output  1  sum/cout hold a completed result.
- res_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result A+B+cin, modulo 2^WIDTH.
- cout  output  1  carry out of the most-significant slice.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset: on a rising edge with rst_n=0:
  - state=IDLE, slice index=0, carry=0.
  - Operand registers, sum and cout = 0; res_valid=0; busy=0.
- Reset wins over every other event, including mid-RUN and DONE. An in-flight operation is discarded with no result.
- start_ready = (state==IDLE), decoded from state. It is 1 in the first cycle after reset is released.
- States IDLE, RUN, DONE:
  - IDLE: on start_valid=1 at an edge, capture a_in, b_in, and carry<=cin; clear sum and idx; go to RUN. Otherwise hold.
  - RUN: each edge computes {c, s} = A[idx*CHUNK +: CHUNK] + B[idx*CHUNK +: CHUNK] + carry. Write s to sum[idx*CHUNK +: CHUNK], set carry<=c, idx<=idx+1.
  - RUN exit: when idx==NCHUNK-1 at the edge, also cout<=c, idx<=0, go to DONE.
  - DONE: res_valid=1; sum and cout are stable. On res_ready=1 at an edge, go to IDLE and set res_valid=0.
- Slice arithmetic: CHUNK+1 bits wide. Carry propagates only through the carry register, never combinationally across slices.
- Latency: if an operation is accepted at edge T, res_valid is high from edge T+NCHUNK. With defaults, that is 4 cycles.
- Input sampling: a_in, b_in and cin are sampled only at the accept edge. Later changes during RUN/DONE have no effect.
- While busy: start_valid is ignored (start_ready=0). No queueing.
- No same-cycle turnaround: the DONE->IDLE edge does not accept a new start. The earliest next accept is the following edge.
- res_ready while not in DONE is ignored.
- sum and cout hold their last result in IDLE until the next accept clears sum.
- cout changes only on the final RUN edge.
- idx width is clog2(NCHUNK), minimum 1. idx never exceeds NCHUNK-1.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with start_valid=1 -> res_valid=0, busy=0, sum=0, cout=0; start_ready=1 on the first cycle after release; no operation starts during reset.
- Basic add: a=0x123, b=0x456, cin=0, res_ready=1 -> sum=0x579, cout=0, res_valid high exactly 4 edges after the accept edge, for 1 cycle.
- Full carry ripple: a=0xFFF, b=0x001, cin=0 -> sum=0x000, cout=1. Also a=0x7FF, b=0x800, cin=1 -> sum=0x000, cout=1.
- Backpressure: a=0x0AB, b=0x054, cin=1, res_ready held 0 for 5 cycles -> res_valid stays 1 with sum=0x100, cout=0 stable. A start_valid pulse in that window is not accepted. After res_ready=1, IDLE is reached and a start is accepted only on the next edge.
- Operand change after accept: a=0x111, b=0x222 accepted, then a_in/b_in/cin driven to 0xFFF/0xFFF/1 during RUN -> sum=0x333, cout=0.
- Reset mid-operation: rst_n=0 for one edge while idx=2 -> next cycle IDLE, busy=0, res_valid=0, sum=0. The following op a=0x800, b=0x800, cin=0 yields sum=0x000, cout=1.
